dca_matrix_slx_responder: RTL and testbench
===========================================

// Module: dca_matrix_slx_responder
// PURPOSE
//  SLX memory responder (slave end) for the DCA matrix masters (ma/mb/mc ports); backed by on-chip word SRAM.
//  Accepts slxq read/write bursts, returns slxy read data / single write reply; serves as tile/scratch memory or bench target.
// PARAMETERS
//  BW_ADDR      32      address width
//  BW_DATA      128     data width; power of two, >=32
//  HAS_BURDEN   0       1: echo slxqburden on slxyburden; 0: slxyburden=0
//  BW_BURDEN    1       burden width
//  BASE_ADDR    0       byte address of word 0; BW_DATA/8-aligned
//  DEPTH        1024    SRAM words; power of two
// PORTS
//  clk            in   1             clock
//  rstnn          in   1             async active-low reset
//  slxqdready     out  2             [0] read-request ready, [1] write-beat ready
//  slxqvalid      in   1             request beat valid
//  slxqlast       in   1             last write beat
//  slxqwrite      in   1             1 write beat, 0 read request
//  slxqlen        in   8             beats-1 (sampled on first beat)
//  slxqsize       in   3             log2 bytes/beat
//  slxqburst      in   2             0 FIXED, 1 INCR, others reserved
//  slxqwstrb      in   BW_DATA/8     byte enables
//  slxqwdata      in   BW_DATA       write data
//  slxqaddr       in   BW_ADDR       byte address (sampled on first beat)
//  slxqburden     in   BW_BURDEN     sideband tag (sampled on first beat)
//  slxydready     in   2             [0] read-data ready, [1] write-reply ready
//  slxyvalid      out  1             reply beat valid
//  slxylast       out  1             last reply beat (always 1 on write reply)
//  slxywreply     out  1             1 write reply, 0 read data
//  slxyresp       out  2             00 OKAY, 10 SLVERR, 11 DECERR
//  slxyrdata      out  BW_DATA       read data (0 on write reply)
//  slxyburden     out  BW_BURDEN     returned tag
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, SRAM contents undefined. Reset mid-burst aborts; no reply for aborted burst.
//  Req beat fires when slxqvalid & slxqdready[slxqwrite]; reply beat fires when slxyvalid & slxydready[slxywreply].
//  FSM IDLE/WRITE/WREPLY/READ; one burst at a time, no reordering.
//   IDLE:   slxqdready=2'b11. Write beat -> WRITE (that beat is beat 0). Read request -> READ.
//   WRITE:  slxqdready=2'b10; a beat every cycle accepted. Beat with slxqlast -> WREPLY.
//   WREPLY: slxqdready=0; slxyvalid=1,wreply=1,last=1 held until fired -> IDLE. Reply valid the cycle after last beat.
//   READ:   slxqdready=0; issue len+1 beats in order; after last beat fires -> IDLE (next cycle).
//  Address: word index = (addr-BASE_ADDR)>>log2(BW_DATA/8); INCR +1/beat, FIXED constant; no wrap; low addr bits ignored.
//  Write: byte i written iff wstrb[i]; later-beat slxqaddr/len ignored.
//  Read timing: first slxyvalid 2 cycles after request fires; 1 beat/cycle while slxydready[0]=1.
//   Backpressure: rdata/last/resp held stable while valid & !ready; 2-entry output buffer, no bubbles on release.
//  Errors (resp for whole burst; all beats still consumed/produced):
//   DECERR 11: any beat index >= DEPTH or addr<BASE_ADDR -> those writes dropped, those read beats rdata=0.
//   SLVERR 10: slxqsize != log2(BW_DATA/8), burst in {2,3}, or write beat count != len+1; writes still performed.
//   DECERR overrides SLVERR. Beats after count len+1 before slxqlast: accepted, dropped.
//  slxyburden = HAS_BURDEN ? burden of first beat : 0; registered at burst start.
//  Read request in WRITE: not accepted (dready[0]=0), held by master until IDLE.
//  Same word written and read in back-to-back bursts: read returns new data.
// TESTING
//  T1 write INCR len=3 addr=0x40 BW_DATA=128, data 1..4, wstrb all 1 -> wreply resp=00 1 cycle after last; read len=3 @0x40 -> 1,2,3,4, last on 4th.
//  T2 read len=7 with slxydready[0] toggling 1010.. -> 8 beats in order, data stable while stalled, no loss/duplication.
//  T3 write wstrb=0x000F then read same word -> only bytes 0-3 updated, other bytes keep prior value.
//  T4 read len=1 at word DEPTH-1 -> beat0 valid data, beat1 rdata=0, resp=11 on both, last on beat1.
//  T5 write len=3 with slxqlast on beat 2 -> reply resp=10, words 0-2 written; slxqsize=3 read -> resp=10.
//  T6 assert rstnn=0 during READ beat 3 of 8 -> all outputs 0 async; after release IDLE, dready=11, new request served.

Source files
------------

// File: rtl/dca_matrix_slx_responder_if.sv
// SLX request/reply channel bundle between a DCA matrix master and a memory responder.
interface dca_matrix_slx_responder_if #(
    parameter int BW_ADDR   = 32,
    parameter int BW_DATA   = 128,
    parameter int BW_BURDEN = 1
);
    logic [1:0]             slxqdready;
    logic                   slxqvalid;
    logic                   slxqlast;
    logic                   slxqwrite;
    logic [7:0]             slxqlen;
    logic [2:0]             slxqsize;
    logic [1:0]             slxqburst;
    logic [BW_DATA/8-1:0]   slxqwstrb;
    logic [BW_DATA-1:0]     slxqwdata;
    logic [BW_ADDR-1:0]     slxqaddr;
    logic [BW_BURDEN-1:0]   slxqburden;

    logic [1:0]             slxydready;
    logic                   slxyvalid;
    logic                   slxylast;
    logic                   slxywreply;
    logic [1:0]             slxyresp;
    logic [BW_DATA-1:0]     slxyrdata;
    logic [BW_BURDEN-1:0]   slxyburden;

    modport master (
        input  slxqdready,
        output slxqvalid, slxqlast, slxqwrite, slxqlen, slxqsize, slxqburst,
        output slxqwstrb, slxqwdata, slxqaddr, slxqburden,
        output slxydready,
        input  slxyvalid, slxylast, slxywreply, slxyresp, slxyrdata, slxyburden
    );

    modport slave (
        output slxqdready,
        input  slxqvalid, slxqlast, slxqwrite, slxqlen, slxqsize, slxqburst,
        input  slxqwstrb, slxqwdata, slxqaddr, slxqburden,
        input  slxydready,
        output slxyvalid, slxylast, slxywreply, slxyresp, slxyrdata, slxyburden
    );
endinterface

// File: rtl/dca_matrix_slx_responder.sv
// SLX memory responder: serves read/write bursts from an on-chip word SRAM,
// one burst at a time, with a 2-entry read output buffer for backpressure.
module dca_matrix_slx_responder #(
    parameter int                 BW_ADDR    = 32,
    parameter int                 BW_DATA    = 128,
    parameter int                 HAS_BURDEN = 0,
    parameter int                 BW_BURDEN  = 1,
    parameter logic [BW_ADDR-1:0] BASE_ADDR  = '0,
    parameter int                 DEPTH      = 1024
) (
    input logic                        clk,
    input logic                        rstnn,
    dca_matrix_slx_responder_if.slave  slx
);
    localparam int WSTRB    = BW_DATA / 8;
    localparam int ADDR_LSB = $clog2(WSTRB);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam logic [BW_ADDR-1:0] IDX_LIMIT  = BW_ADDR'(DEPTH);
    localparam logic [BW_ADDR:0]   IDX_LIMITX = (BW_ADDR+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_WREPLY,
        S_READ
    } state_t;

    state_t                 state_q, state_d;
    logic                   alive_q;
    logic [BW_ADDR-1:0]     idx_q;
    logic                   fixed_q;
    logic [7:0]             len_q;
    logic [8:0]             bcnt_q;
    logic                   oob_q;
    logic                   dec_q;
    logic                   slv_q;
    logic [BW_BURDEN-1:0]   burden_q;
    logic [BW_DATA-1:0]     bdata_q [2];
    logic                   blast_q [2];
    logic                   wp_q, rp_q;
    logic [1:0]             occ_q;

    logic [BW_DATA-1:0]     mem [DEPTH];

    logic                   first;
    logic [BW_ADDR-1:0]     first_off, first_idx, cur_idx;
    logic [BW_ADDR:0]       last_idx;
    logic                   below_base, first_oob, cur_oob, rd_dec, req_slv;
    logic [8:0]             cur_cnt;
    logic [7:0]             cur_len;
    logic                   cur_fixed, beat_extra, wr_cnt_bad, do_write;
    logic                   wr_fire, rd_fire, rd_issue, pop, push;
    logic [BW_DATA-1:0]     rd_word;
    logic [1:0]             resp_c;

    // Decode the current request beat: word index, range and protocol errors.
    always_comb begin
        first      = (state_q == S_IDLE);
        below_base = (slx.slxqaddr < BASE_ADDR);
        first_off  = slx.slxqaddr - BASE_ADDR;
        first_idx  = first_off >> ADDR_LSB;
        first_oob  = below_base || (first_idx >= IDX_LIMIT);
        last_idx   = {1'b0, first_idx}
                   + ((slx.slxqburst == 2'd0) ? '0 : {{(BW_ADDR-7){1'b0}}, slx.slxqlen});
        rd_dec     = below_base || (last_idx >= IDX_LIMITX);
        req_slv    = (slx.slxqsize != 3'(ADDR_LSB)) || slx.slxqburst[1];
        cur_idx    = first ? first_idx : idx_q;
        cur_oob    = first ? first_oob : (oob_q || (idx_q >= IDX_LIMIT));
        cur_cnt    = first ? 9'd0 : bcnt_q;
        cur_len    = first ? slx.slxqlen : len_q;
        cur_fixed  = first ? (slx.slxqburst == 2'd0) : fixed_q;
        beat_extra = (cur_cnt > {1'b0, cur_len});
        wr_cnt_bad = slx.slxqlast && (cur_cnt != {1'b0, cur_len});
        wr_fire    = slx.slxqvalid && slx.slxqwrite && slx.slxqdready[1];
        rd_fire    = slx.slxqvalid && !slx.slxqwrite && slx.slxqdready[0];
        do_write   = wr_fire && !cur_oob && !beat_extra;
        pop        = (state_q == S_READ) && (occ_q != 2'd0) && slx.slxydready[0];
        rd_issue   = (state_q == S_READ) && (bcnt_q <= {1'b0, len_q})
                   && ((occ_q != 2'd2) || pop);
        push       = rd_issue;
        rd_word    = '0;
        if (!cur_oob) begin
            rd_word = mem[idx_q[IDX_W-1:0]];
        end
        resp_c     = dec_q ? 2'b11 : (slv_q ? 2'b10 : 2'b00);
    end

    // SRAM write port with per-byte enables; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < WSTRB; b++) begin
                if (slx.slxqwstrb[b]) begin
                    mem[cur_idx[IDX_W-1:0]][8*b +: 8] <= slx.slxqwdata[8*b +: 8];
                end
            end
        end
    end

    // Burst bookkeeping, error accumulation and the read output buffer.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q  <= S_IDLE;
            alive_q  <= 1'b0;
            idx_q    <= '0;
            fixed_q  <= 1'b0;
            len_q    <= '0;
            bcnt_q   <= '0;
            oob_q    <= 1'b0;
            dec_q    <= 1'b0;
            slv_q    <= 1'b0;
            burden_q <= '0;
            bdata_q  <= '{default: '0};
            blast_q  <= '{default: 1'b0};
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            occ_q    <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            if (wr_fire) begin
                idx_q   <= cur_fixed ? cur_idx : cur_idx + BW_ADDR'(1);
                fixed_q <= cur_fixed;
                bcnt_q  <= beat_extra ? cur_cnt : cur_cnt + 9'd1;
                oob_q   <= cur_oob;
                dec_q   <= (first ? 1'b0 : dec_q) | (cur_oob & ~beat_extra);
                slv_q   <= (first ? req_slv : slv_q) | wr_cnt_bad;
                if (first) begin
                    len_q    <= slx.slxqlen;
                    burden_q <= (HAS_BURDEN != 0) ? slx.slxqburden : '0;
                end
            end else if (rd_fire) begin
                idx_q    <= first_idx;
                fixed_q  <= (slx.slxqburst == 2'd0);
                len_q    <= slx.slxqlen;
                bcnt_q   <= '0;
                oob_q    <= first_oob;
                dec_q    <= rd_dec;
                slv_q    <= req_slv;
                burden_q <= (HAS_BURDEN != 0) ? slx.slxqburden : '0;
            end else if (rd_issue) begin
                idx_q         <= fixed_q ? idx_q : idx_q + BW_ADDR'(1);
                bcnt_q        <= bcnt_q + 9'd1;
                oob_q         <= cur_oob;
                bdata_q[wp_q] <= rd_word;
                blast_q[wp_q] <= (bcnt_q == {1'b0, len_q});
                wp_q          <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            occ_q <= occ_q + 2'(push) - 2'(pop);
        end
    end

    // Next-state and handshake outputs; everything idles at zero until out of reset.
    always_comb begin
        state_d            = state_q;
        slx.slxqdready     = 2'b00;
        slx.slxyvalid      = 1'b0;
        slx.slxylast       = 1'b0;
        slx.slxywreply     = 1'b0;
        slx.slxyresp       = 2'b00;
        slx.slxyrdata      = '0;
        slx.slxyburden     = '0;
        case (state_q)
            S_IDLE: begin
                slx.slxqdready = alive_q ? 2'b11 : 2'b00;
                if (wr_fire) begin
                    state_d = slx.slxqlast ? S_WREPLY : S_WRITE;
                end else if (rd_fire) begin
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                slx.slxqdready = 2'b10;
                if (wr_fire && slx.slxqlast) begin
                    state_d = S_WREPLY;
                end
            end
            S_WREPLY: begin
                slx.slxyvalid  = 1'b1;
                slx.slxywreply = 1'b1;
                slx.slxylast   = 1'b1;
                slx.slxyresp   = resp_c;
                slx.slxyburden = burden_q;
                if (slx.slxydready[1]) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (occ_q != 2'd0) begin
                    slx.slxyvalid  = 1'b1;
                    slx.slxylast   = blast_q[rp_q];
                    slx.slxyresp   = resp_c;
                    slx.slxyrdata  = bdata_q[rp_q];
                    slx.slxyburden = burden_q;
                end
                if (pop && blast_q[rp_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dca_matrix_slx_responder.sv
// Scoreboard bench for the SLX responder: stimulus pushes expected replies,
// a negedge monitor pops and compares every reply beat as it fires.
module tb_dca_matrix_slx_responder;
    localparam int BW_ADDR   = 32;
    localparam int BW_DATA   = 128;
    localparam int BW_BURDEN = 4;
    localparam int DEPTH     = 64;

    typedef struct packed {
        logic                 wreply;
        logic                 last;
        logic [1:0]           resp;
        logic [BW_BURDEN-1:0] burden;
        logic [BW_DATA-1:0]   rdata;
    } reply_t;

    logic clk = 1'b0;
    logic rstnn;
    int testsRun = 0;
    int testsFailed = 0;
    int replyCount = 0;
    reply_t expQ[$];
    logic [BW_DATA-1:0] beatData [8];
    logic [BW_DATA-1:0] expData [8];
    bit toggleReady = 1'b0;
    bit stallPending = 1'b0;
    reply_t stallSnap;

    dca_matrix_slx_responder_if #(.BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_BURDEN(BW_BURDEN)) slx ();

    dca_matrix_slx_responder #(
        .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .HAS_BURDEN(1), .BW_BURDEN(BW_BURDEN),
        .BASE_ADDR(32'h0), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rstnn(rstnn),
        .slx(slx)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [143:0] actual, input logic [143:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Wait (bounded) until every expected reply has been observed.
    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, " drain"}, 144'(expQ.size()), 144'(0));
    endtask

    // Issue one burst, queue its expected replies and check reply latency.
    task automatic applyStimulus(input string tag, input bit isWrite, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                 input int nBeats, input logic [15:0] wstrb, input logic [3:0] burden,
                                 input logic [1:0] expResp, input bit doDrain);
        bit accepted;
        int waitCycles;
        if (isWrite) begin
            expQ.push_back(reply_t'({1'b1, 1'b1, expResp, burden, 128'h0}));
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                expQ.push_back(reply_t'({1'b0, (i == int'(len)), expResp, burden, expData[i]}));
            end
        end
        @(posedge clk); #1;
        for (int b = 0; b < (isWrite ? nBeats : 1); b++) begin
            slx.slxqvalid  = 1'b1;
            slx.slxqwrite  = isWrite;
            slx.slxqlast   = isWrite && (b == nBeats - 1);
            slx.slxqlen    = len;
            slx.slxqsize   = size;
            slx.slxqburst  = burst;
            slx.slxqaddr   = addr;
            slx.slxqburden = burden;
            slx.slxqwstrb  = wstrb;
            slx.slxqwdata  = isWrite ? beatData[b] : '0;
            accepted = 1'b0;
            waitCycles = 0;
            while (!accepted && waitCycles < 50) begin
                @(negedge clk);
                accepted = slx.slxqdready[isWrite];
                @(posedge clk); #1;
                waitCycles++;
            end
            if (!accepted) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL %s accept-timeout: beat %0d not accepted, required within 50 cycles", tag, b);
            end
        end
        slx.slxqvalid = 1'b0;
        slx.slxqlast  = 1'b0;
        if (isWrite) begin
            @(negedge clk);
            checkOutput({tag, " wreply-latency"}, 144'(slx.slxyvalid & slx.slxywreply), 144'(1));
        end else begin
            @(negedge clk);
            checkOutput({tag, " read-gap"}, 144'(slx.slxyvalid), 144'(0));
            @(negedge clk);
            checkOutput({tag, " read-latency"}, 144'(slx.slxyvalid), 144'(1));
        end
        if (doDrain) begin
            waitDrain(tag);
        end
    endtask

    // Reply-side ready driver: always ready, or toggling read-data ready.
    initial begin
        slx.slxydready = 2'b11;
        forever begin
            @(posedge clk); #1;
            if (toggleReady) slx.slxydready[0] = ~slx.slxydready[0];
            else             slx.slxydready[0] = 1'b1;
        end
    end

    // Monitor: compare each reply beat as it fires, and check held values while stalled.
    always @(negedge clk) begin : monitor
        reply_t act;
        reply_t exp;
        if (!rstnn) begin
            stallPending = 1'b0;
        end else if (slx.slxyvalid) begin
            act = {slx.slxywreply, slx.slxylast, slx.slxyresp, slx.slxyburden, slx.slxyrdata};
            if (stallPending) begin
                checkOutput("stall-hold", 144'(act), 144'(stallSnap));
            end
            if (slx.slxydready[slx.slxywreply]) begin
                stallPending = 1'b0;
                replyCount++;
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected-reply: got %h, expected no reply", act);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput($sformatf("reply#%0d", replyCount), 144'(act), 144'(exp));
                end
            end else begin
                stallPending = 1'b1;
                stallSnap = act;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int n;
        rstnn = 1'b0;
        slx.slxqvalid = 1'b0; slx.slxqlast = 1'b0; slx.slxqwrite = 1'b0;
        slx.slxqlen = '0; slx.slxqsize = '0; slx.slxqburst = '0; slx.slxqwstrb = '0;
        slx.slxqwdata = '0; slx.slxqaddr = '0; slx.slxqburden = '0;
        repeat (3) @(posedge clk); #1;
        checkOutput("reset-outputs", 144'({slx.slxqdready, slx.slxyvalid, slx.slxylast, slx.slxywreply,
                    slx.slxyresp, slx.slxyburden, slx.slxyrdata}), 144'(0));
        rstnn = 1'b1;
        repeat (2) @(posedge clk); #1;
        checkOutput("idle-dready", 144'(slx.slxqdready), 144'(2'b11));

        // T1: INCR write of 1..4 at 0x40, read back.
        for (int i = 0; i < 4; i++) beatData[i] = 128'(i + 1);
        applyStimulus("T1 write", 1'b1, 32'h40, 8'd3, 3'd4, 2'd1, 4, 16'hFFFF, 4'h5, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) expData[i] = 128'(i + 1);
        applyStimulus("T1 read", 1'b0, 32'h40, 8'd3, 3'd4, 2'd1, 1, 16'h0, 4'h6, 2'b00, 1'b1);

        // T2: 8-beat read with toggling read-data ready.
        for (int i = 0; i < 8; i++) beatData[i] = 128'h1234_0000_0000_0000_0000_0000_0000_00A0 + 128'(i);
        applyStimulus("T2 write", 1'b1, 32'h100, 8'd7, 3'd4, 2'd1, 8, 16'hFFFF, 4'h2, 2'b00, 1'b1);
        for (int i = 0; i < 8; i++) expData[i] = 128'h1234_0000_0000_0000_0000_0000_0000_00A0 + 128'(i);
        toggleReady = 1'b1;
        applyStimulus("T2 read", 1'b0, 32'h100, 8'd7, 3'd4, 2'd1, 1, 16'h0, 4'h3, 2'b00, 1'b1);
        toggleReady = 1'b0;

        // T3: partial byte write keeps the untouched bytes.
        beatData[0] = {4{32'h1111_1111}};
        applyStimulus("T3 full write", 1'b1, 32'h80, 8'd0, 3'd4, 2'd1, 1, 16'hFFFF, 4'h7, 2'b00, 1'b1);
        beatData[0] = {4{32'hFFFF_FFFF}};
        applyStimulus("T3 strb write", 1'b1, 32'h80, 8'd0, 3'd4, 2'd1, 1, 16'h000F, 4'h7, 2'b00, 1'b1);
        expData[0] = 128'h11111111_11111111_11111111_FFFFFFFF;
        applyStimulus("T3 read", 1'b0, 32'h80, 8'd0, 3'd4, 2'd1, 1, 16'h0, 4'h8, 2'b00, 1'b1);

        // T4: read crossing the top of memory.
        beatData[0] = 128'hCAFE;
        applyStimulus("T4 write", 1'b1, 32'h3F0, 8'd0, 3'd4, 2'd1, 1, 16'hFFFF, 4'h9, 2'b00, 1'b1);
        expData[0] = 128'hCAFE;
        expData[1] = 128'h0;
        applyStimulus("T4 read", 1'b0, 32'h3F0, 8'd1, 3'd4, 2'd1, 1, 16'h0, 4'hA, 2'b11, 1'b1);

        // T5: short write burst and wrong size.
        for (int i = 0; i < 3; i++) beatData[i] = 128'h51 + 128'(i);
        applyStimulus("T5 short write", 1'b1, 32'h0, 8'd3, 3'd4, 2'd1, 3, 16'hFFFF, 4'hB, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) expData[i] = 128'h51 + 128'(i);
        applyStimulus("T5 read", 1'b0, 32'h0, 8'd2, 3'd4, 2'd1, 1, 16'h0, 4'hC, 2'b00, 1'b1);
        expData[0] = 128'h51;
        applyStimulus("T5 size read", 1'b0, 32'h0, 8'd0, 3'd3, 2'd1, 1, 16'h0, 4'hD, 2'b10, 1'b1);

        // T6: reset in the middle of an 8-beat read.
        for (int i = 0; i < 8; i++) beatData[i] = 128'hB0 + 128'(i);
        applyStimulus("T6 write", 1'b1, 32'h200, 8'd7, 3'd4, 2'd1, 8, 16'hFFFF, 4'h1, 2'b00, 1'b1);
        for (int i = 0; i < 8; i++) expData[i] = 128'hB0 + 128'(i);
        applyStimulus("T6 read", 1'b0, 32'h200, 8'd7, 3'd4, 2'd1, 1, 16'h0, 4'h4, 2'b00, 1'b0);
        n = 0;
        while (expQ.size() > 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("T6 beats-before-reset", 144'(expQ.size()), 144'(5));
        rstnn = 1'b0;
        #1;
        checkOutput("T6 async-reset", 144'({slx.slxqdready, slx.slxyvalid, slx.slxylast, slx.slxywreply,
                    slx.slxyresp, slx.slxyburden, slx.slxyrdata}), 144'(0));
        expQ.delete();
        repeat (2) @(posedge clk); #1;
        rstnn = 1'b1;
        repeat (2) @(posedge clk); #1;
        checkOutput("T6 idle-dready", 144'(slx.slxqdready), 144'(2'b11));
        beatData[0] = 128'h77;
        applyStimulus("T6 new write", 1'b1, 32'h280, 8'd0, 3'd4, 2'd1, 1, 16'hFFFF, 4'hE, 2'b00, 1'b1);
        expData[0] = 128'h77;
        applyStimulus("T6 new read", 1'b0, 32'h280, 8'd0, 3'd4, 2'd1, 1, 16'h0, 4'hF, 2'b00, 1'b1);

        repeat (3) @(posedge clk); #1;
        checkOutput("final-queue-empty", 144'(expQ.size()), 144'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
